// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle control sequencer for the 4-bit RISC core. Each instruction
// walks FETCH -> DECODE -> (EXEC -> WB | MEM [-> WB]) -> FETCH, or parks in
// HALTED until resume. Strobes are decoded combinationally from the state
// register and the latched opcode (ir); all outputs read 0 while rst is high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   instr_valid  fetched instruction present on opcode (sampled in FETCH)
//   opcode       opcode from instruction memory
//   mem_ready    data memory completes the current request
//   resume       leave HALTED
//   fetch_req    request an instruction (FETCH)
//   ir_load      latch the instruction register (FETCH with instr_valid)
//   pc_inc       increment PC (DECODE)
//   alu_sel      ALU operation (EXEC only, else 0)
//   alu_en       ALU operation active (EXEC)
//   reg_we       register file write (WB)
//   mem_req      data memory request (MEM)
//   mem_we       1 = store, 0 = load; valid only with mem_req
//   halted       core halted
//   illegal      one-cycle pulse in DECODE on an illegal opcode
//   bus_err      one-cycle pulse on a memory timeout
//   instr_count  retired instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_SEL_W   = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 mem_ready,
  input  logic                 resume,
  output logic                 fetch_req,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 alu_en,
  output logic                 reg_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;

  // The timeout counter only has to reach MEM_TIMEOUT-1.
  localparam int              TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [2:0]          state, state_d;
  logic [OPCODE_W-1:0] ir;
  logic [TO_W-1:0]     to_cnt;
  logic [CNT_W-1:0]    count_q;
  logic                retire, to_clr, to_inc;

  // ---------------------------------------------------------------------------
  // Opcode classification of the latched instruction
  // ---------------------------------------------------------------------------
  logic       hi_nz;
  logic [3:0] op4;
  logic       is_nop, is_load, is_store, is_alu, is_halt;
  logic [2:0] alu_code;

  // Any set bit above the 4-bit opcode field makes the instruction illegal.
  if (OPCODE_W > 4) begin : g_wide
    assign hi_nz = |ir[OPCODE_W-1:4];
  end else begin : g_narrow
    assign hi_nz = 1'b0;
  end

  assign op4      = ir[3:0];
  assign is_nop   = !hi_nz && (op4 == 4'h0);
  assign is_load  = !hi_nz && (op4 == 4'h1);
  assign is_store = !hi_nz && (op4 == 4'h2);
  assign is_alu   = !hi_nz && (op4 >= 4'h3) && (op4 <= 4'h7);
  assign is_halt  = !hi_nz && (op4 == 4'hf);

  always_comb begin
    case (op4)
      4'h3:    alu_code = 3'd0;  // ADD
      4'h4:    alu_code = 3'd1;  // SUB
      4'h5:    alu_code = 3'd2;  // AND
      4'h6:    alu_code = 3'd3;  // OR
      4'h7:    alu_code = 3'd4;  // NOT
      default: alu_code = 3'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state;
    retire    = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    alu_sel   = '0;
    alu_en    = 1'b0;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;

    case (state)
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        pc_inc = 1'b1;
        if (is_nop) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_halt) begin
          retire  = 1'b1;
          state_d = HALTED;
        end else if (is_load || is_store) begin
          to_clr  = 1'b1;
          state_d = MEM;
        end else if (is_alu) begin
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_en  = 1'b1;
        alu_sel = ALU_SEL_W'(alu_code);
        state_d = WB;
      end
      WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        // A completion in the timeout cycle takes priority over the bus error.
        if (mem_ready) begin
          to_clr  = 1'b1;
          retire  = is_store;
          state_d = is_load ? WB : FETCH;
        end else if (to_cnt == TO_LAST) begin
          bus_err = 1'b1;
          to_clr  = 1'b1;
          state_d = FETCH;
        end else begin
          to_inc = 1'b1;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (resume) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      fetch_req = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      alu_sel   = '0;
      alu_en    = 1'b0;
      reg_we    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end
  end

  assign instr_count = rst ? '0 : count_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      ir      <= '0;
      to_cnt  <= '0;
      count_q <= '0;
    end else begin
      state <= state_d;
      if (state == FETCH && instr_valid) ir <= opcode;
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + 1'b1;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Self-checking bench for multicycle_control_fsm, built with OPCODE_W=6,
// CNT_W=4 and MEM_TIMEOUT=4 so wide-opcode legality, counter wrap and the
// timeout boundary are all reachable. The reference model describes each
// instruction as the sequence of cycles it should take and the strobes
// visible in each, derived from the opcode class; it also tracks the
// retired-instruction count.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int OW = 6;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int MT = 4;

  localparam int C_NOP = 0, C_LOAD = 1, C_STORE = 2, C_ALU = 3, C_HALT = 4, C_ILL = 5;

  typedef struct packed {
    logic          fetch_req;
    logic          ir_load;
    logic          pc_inc;
    logic [AW-1:0] alu_sel;
    logic          alu_en;
    logic          reg_we;
    logic          mem_req;
    logic          mem_we;
    logic          halted;
    logic          illegal;
    logic          bus_err;
  } outs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          mem_ready = 1'b0;
  logic          resume = 1'b0;
  logic          fetch_req, ir_load, pc_inc, alu_en, reg_we;
  logic          mem_req, mem_we, halted, illegal, bus_err;
  logic [AW-1:0] alu_sel;
  logic [CW-1:0] instr_count;

  outs_t         act;
  logic [CW-1:0] model_cnt;
  int            n_checks = 0;
  int            n_fail   = 0;

  multicycle_control_fsm #(
    .OPCODE_W(OW), .ALU_SEL_W(AW), .CNT_W(CW), .MEM_TIMEOUT(MT)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .mem_ready(mem_ready), .resume(resume), .fetch_req(fetch_req),
    .ir_load(ir_load), .pc_inc(pc_inc), .alu_sel(alu_sel), .alu_en(alu_en),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign act = {fetch_req, ir_load, pc_inc, alu_sel, alu_en, reg_we,
                mem_req, mem_we, halted, illegal, bus_err};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic int op_class(input logic [OW-1:0] op);
    int v;
    v = int'(op);
    if (v == 0)            return C_NOP;
    if (v == 1)            return C_LOAD;
    if (v == 2)            return C_STORE;
    if (v >= 3 && v <= 7)  return C_ALU;
    if (v == 15)           return C_HALT;
    return C_ILL;
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare all strobes
  // shortly afterwards (well before the next rising edge).
  task automatic step(input logic r, input logic iv, input logic [OW-1:0] op,
                      input logic mr, input logic rs, input outs_t exp,
                      input string tag);
    @(negedge clk);
    rst = r; instr_valid = iv; opcode = op; mem_ready = mr; resume = rs;
    #1;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: strobes got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_count(input string tag);
    n_checks++;
    if (instr_count !== model_cnt) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected %0d", tag, instr_count, model_cnt);
    end
  endtask

  task automatic idle_check(input string tag);
    outs_t e;
    e = '0; e.fetch_req = 1'b1;
    step(1'b0, 1'b0, OW'($urandom), 1'($urandom), 1'($urandom), e, tag);
    check_count(tag);
  endtask

  // Runs one instruction from FETCH back to FETCH (or through HALTED).
  //   gap   : FETCH cycles with instr_valid=0 before the instruction arrives
  //   delay : MEM cycles with mem_ready=0 before it rises (>= MT times out)
  //   hold  : HALTED cycles before resume is raised
  task automatic do_instr(input logic [OW-1:0] op, input int gap, input int delay,
                          input int hold, input string tag);
    outs_t e;
    int    cls;
    logic  rdy;
    cls = op_class(op);

    for (int i = 0; i < gap; i++) begin
      e = '0; e.fetch_req = 1'b1;
      step(1'b0, 1'b0, OW'($urandom), 1'($urandom), 1'($urandom), e, {tag, " idle"});
    end

    e = '0; e.fetch_req = 1'b1; e.ir_load = 1'b1;
    step(1'b0, 1'b1, op, 1'($urandom), 1'($urandom), e, {tag, " fetch"});
    check_count(tag);

    e = '0; e.pc_inc = 1'b1; e.illegal = (cls == C_ILL);
    step(1'b0, 1'($urandom), OW'($urandom), 1'($urandom), 1'($urandom), e, {tag, " decode"});
    if (cls == C_NOP || cls == C_HALT) model_cnt++;

    if (cls == C_ALU) begin
      e = '0; e.alu_en = 1'b1; e.alu_sel = AW'(int'(op) - 3);
      step(1'b0, 1'($urandom), OW'($urandom), 1'($urandom), 1'($urandom), e, {tag, " exec"});
      e = '0; e.reg_we = 1'b1;
      step(1'b0, 1'($urandom), OW'($urandom), 1'($urandom), 1'($urandom), e, {tag, " wb"});
      model_cnt++;
    end

    if (cls == C_LOAD || cls == C_STORE) begin
      rdy = 1'b0;
      for (int k = 0; k < MT; k++) begin
        rdy = (k == delay);
        e = '0; e.mem_req = 1'b1; e.mem_we = (cls == C_STORE);
        e.bus_err = !rdy && (k == MT - 1);
        step(1'b0, 1'($urandom), OW'($urandom), rdy, 1'($urandom), e, {tag, " mem"});
        if (rdy) break;
      end
      if (rdy) begin
        if (cls == C_LOAD) begin
          e = '0; e.reg_we = 1'b1;
          step(1'b0, 1'($urandom), OW'($urandom), 1'($urandom), 1'($urandom), e, {tag, " wb"});
        end
        model_cnt++;
      end
    end

    if (cls == C_HALT) begin
      for (int i = 0; i < hold; i++) begin
        e = '0; e.halted = 1'b1;
        step(1'b0, 1'b1, OW'($urandom), 1'($urandom), 1'b0, e, {tag, " halted"});
      end
      e = '0; e.halted = 1'b1;
      step(1'b0, 1'($urandom), OW'($urandom), 1'($urandom), 1'b1, e, {tag, " resume"});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    outs_t e;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, OW'($urandom), 1'b1, 1'b1, e, "reset held");
      check_count("reset held");
    end
    model_cnt = '0;
    idle_check("reset release");
  endtask

  task automatic test_alu();
    do_instr(6'b000100, 0, 0, 0, "sub");
    idle_check("sub retire");
    for (int op = 3; op <= 7; op++) do_instr(OW'(op), 0, 0, 0, "alu op");
    idle_check("alu ops retire");
  endtask

  task automatic test_mem();
    do_instr(6'b000001, 0, 3, 0, "load delayed");
    idle_check("load retire");
    do_instr(6'b000010, 0, 0, 0, "store immediate");
    idle_check("store retire");
  endtask

  task automatic test_timeout();
    do_instr(6'b000010, 0, MT, 0, "store timeout");
    idle_check("timeout no retire");
    do_instr(6'b000010, 0, MT - 1, 0, "store ready at limit");
    idle_check("ready at limit retires");
    do_instr(6'b000001, 0, MT + 2, 0, "load timeout");
    idle_check("load timeout no retire");
  endtask

  task automatic test_illegal();
    do_instr(6'b001010, 0, 0, 0, "illegal 1010");
    do_instr(6'b010011, 0, 0, 0, "illegal wide");
    do_instr(6'b011111, 0, 0, 0, "illegal wide halt");
    idle_check("illegal no retire");
  endtask

  task automatic test_halt();
    do_instr(6'b001111, 0, 0, 10, "halt");
    idle_check("halt resume");
  endtask

  task automatic test_wrap();
    outs_t e;
    e = '0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, e, "wrap reset");
    model_cnt = '0;
    for (int i = 0; i < 15; i++) do_instr(6'b000000, 0, 0, 0, "nop fill");
    idle_check("count all ones");
    do_instr(6'b000000, 0, 0, 0, "nop wrap");
    idle_check("count wrapped");
  endtask

  task automatic test_reset_in_mem();
    outs_t e;
    e = '0; e.fetch_req = 1'b1; e.ir_load = 1'b1;
    step(1'b0, 1'b1, 6'b000010, 1'b0, 1'b0, e, "rst-mem fetch");
    e = '0; e.pc_inc = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, e, "rst-mem decode");
    for (int k = 0; k < MT - 1; k++) begin
      e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1;
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, e, "rst-mem wait");
    end
    // Reset lands on the cycle that would otherwise raise bus_err.
    e = '0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, e, "rst-mem abort");
    model_cnt = '0;
    idle_check("rst-mem back to fetch");
  endtask

  task automatic test_random();
    logic [OW-1:0] op;
    logic [OW-1:0] legal [9];
    legal = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0f};
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 8)];
      else                          op = OW'($urandom);
      do_instr(op, $urandom_range(0, 2), $urandom_range(0, MT + 1),
               $urandom_range(0, 3), "random");
    end
    idle_check("random final");
  endtask

  initial begin
    model_cnt = '0;
    test_reset();
    test_alu();
    test_mem();
    test_timeout();
    test_illegal();
    test_halt();
    test_wrap();
    test_reset_in_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised multi-cycle successor to the combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives ALU select, register write, memory request, PC increment and halt strobes.
- Handles memory handshakes with a timeout, halt/resume, illegal-opcode flagging and a retired-instruction counter.
- Sits between the instruction register/PC path and the ALU, register file and data memory of the 4-bit RISC core.

Parameters:
- OPCODE_W, 4, opcode width. Must be >= 4; any nonzero bit above bit 3 makes the opcode illegal.
- ALU_SEL_W, 3, ALU select width. Must be >= 3.
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum number of MEM-state cycles without mem_ready before a bus error is declared. Must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  fetched instruction is present on opcode
- opcode  in  OPCODE_W  opcode from instruction memory; sampled in FETCH
- mem_ready  in  1  data memory completes the current request
- resume  in  1  leave HALTED
- fetch_req  out  1  request an instruction
- ir_load  out  1  latch the instruction register
- pc_inc  out  1  increment PC
- alu_sel  out  ALU_SEL_W  ALU operation
- alu_en  out  1  ALU operation active
- reg_we  out  1  register file write
- mem_req  out  1  data memory request
- mem_we  out  1  store when 1, load when 0; valid only with mem_req
- halted  out  1  core halted
- illegal  out  1  one-cycle pulse on an illegal opcode
- bus_err  out  1  one-cycle pulse on a memory timeout
- instr_count  out  CNT_W  retired instruction count; wraps modulo 2^CNT_W

Behaviour:
- Opcodes:
  - 0000 NOP, 0001 LOAD, 0010 STORE.
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 NOT.
  - 1111 HALT.
  - All others illegal.
- alu_sel encoding: ADD=0, SUB=1, AND=2, OR=3, NOT=4, zero-extended to ALU_SEL_W. alu_sel is 0 in every state other than EXEC.
- Output style:
  - Outputs are decoded combinationally from the state register and the latched opcode register (ir).
  - While rst is high, all outputs are forced to 0.
- Reset: on the reset edge, state=FETCH, ir=0, the timeout counter is 0 and instr_count is 0. Reset asserted in any state, including MEM mid-handshake, aborts the instruction with no retire and no bus_err.
- FETCH:
  - fetch_req=1.
  - If instr_valid: ir_load=1 in the same cycle, ir<=opcode, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): pc_inc=1, then branch on ir:
  - NOP -> FETCH, retire.
  - HALT -> HALTED, retire.
  - LOAD/STORE -> MEM; the timeout counter clears to 0.
  - ALU op -> EXEC.
  - Illegal -> FETCH; illegal=1 this cycle; no retire.
- EXEC: alu_en=1, alu_sel from ir, then go to WB.
- WB: reg_we=1, retire, then go to FETCH.
- MEM:
  - mem_req=1; mem_we=1 for STORE, 0 for LOAD.
  - If mem_ready: LOAD -> WB; STORE -> FETCH with retire. The timeout counter is cleared.
  - Else the counter increments. When the counter equals MEM_TIMEOUT-1 and mem_ready is still 0, bus_err=1 that cycle, go to FETCH, no retire.
  - mem_ready arriving in the same cycle as the timeout: mem_ready wins and there is no bus_err.
- HALTED:
  - halted=1 and no other strobes.
  - resume=1 -> FETCH.
  - resume is ignored in every other state. instr_valid is ignored while halted.
- Retire: instr_count += 1 on the retiring edge, wrapping from all-ones to 0.
- Latencies, counted from the first FETCH cycle with instr_valid to the return to FETCH:
  - ALU op: 4 cycles.
  - LOAD with immediate mem_ready: 4 cycles.
  - STORE with immediate mem_ready: 3 cycles.
  - NOP/illegal: 2 cycles.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0 while rst is high; on the first cycle after release, fetch_req=1 and instr_count=0.
- opcode=0100 (SUB), instr_valid=1 -> ir_load@c0, pc_inc@c1, alu_en=1 with alu_sel=001@c2, reg_we@c3, FETCH@c4, instr_count=1.
- LOAD with mem_ready delayed 3 cycles -> mem_req=1 and mem_we=0 held for 4 cycles, then reg_we for 1 cycle, then FETCH, retire +1. STORE with immediate mem_ready -> mem_we=1 for 1 cycle, no reg_we.
- STORE with mem_ready held 0 and MEM_TIMEOUT=4 -> exactly 4 mem_req cycles, bus_err pulses in the 4th, return to FETCH, instr_count unchanged. Repeat with mem_ready=1 in that 4th cycle -> no bus_err and the store retires.
- opcode=1010 -> illegal pulses 1 cycle in DECODE, pc_inc=1, no retire. With OPCODE_W=6, opcode=010011 is also illegal.
- HALT -> halted=1 and held for 10 cycles with instr_valid=1 (no fetch_req); resume=1 -> FETCH the next cycle. Separately, preload the count to all-ones (CNT_W=4, 15 NOPs) and issue one more NOP -> instr_count=0. Finally, rst during MEM -> FETCH with no bus_err.
